// File: rtl/edge_arb_pkg.sv
// Shared types and limits for the edge-event arbiter block.
package edge_arb_pkg;
   localparam int MAX_CH = 16;

   typedef enum logic {
      EVT_FALL = 1'b0,
      EVT_RISE = 1'b1
   } evt_type_e;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;
endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event handshake towards the consumer: the arbiter presents and the consumer accepts.
interface edge_event_arbiter_if #(parameter int CH_W = 2);
   logic            evt_valid_o;
   logic [CH_W-1:0] evt_ch_o;
   logic            evt_is_rise_o;
   logic            evt_ready_i;

   modport master (output evt_valid_o, evt_ch_o, evt_is_rise_o, input evt_ready_i);
   modport slave  (input evt_valid_o, evt_ch_o, evt_is_rise_o, output evt_ready_i);
endinterface

// File: rtl/edge_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last_grant+1.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   last_grant_i,
   output logic              grant_valid_o,
   output logic [CH_W-1:0]   grant_idx_o
);
   logic [CH_W-1:0] idx;

   // Walk the distances from farthest to nearest so the nearest requester wins.
   always_comb begin
      grant_valid_o = 1'b0;
      grant_idx_o   = '0;
      idx           = '0;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = CH_W'((int'(last_grant_i) + k) % NUM_CH);
         if (req_i[idx]) begin
            grant_valid_o = 1'b1;
            grant_idx_o   = idx;
         end
      end
   end
endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detection into 1-deep slots, drained round-robin into one output register.
module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_CH-1:0]    sig_i,
   input  logic [NUM_CH-1:0]    rise_en_i,
   input  logic [NUM_CH-1:0]    fall_en_i,
   input  logic                 clear_ovf_i,
   output logic                 pending_o,
   output logic [NUM_CH-1:0]    overflow_o,
   edge_event_arbiter_if.master evt
);
   logic [NUM_CH-1:0] prev_q, pend_q, ptype_q, ovf_q;
   logic [NUM_CH-1:0] pend_d, ptype_d, ovf_d;
   logic [NUM_CH-1:0] rise, fall, edge_det, unload;
   out_state_e        state_q, state_d;
   evt_type_e         type_q, type_d;
   logic [CH_W-1:0]   ch_q, ch_d, last_q, last_d;
   logic              gnt_vld, load;
   logic [CH_W-1:0]   gnt_idx;

   assign rise     = sig_i & ~prev_q & rise_en_i;
   assign fall     = ~sig_i & prev_q & fall_en_i;
   assign edge_det = rise | fall;
   assign load     = (state_q == OUT_EMPTY) || evt.evt_ready_i;

   rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_rr (
      .req_i        (pend_q),
      .last_grant_i (last_q),
      .grant_valid_o(gnt_vld),
      .grant_idx_o  (gnt_idx)
   );

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      type_d  = type_q;
      last_d  = last_q;
      unload  = '0;
      if (load) begin
         if (gnt_vld) begin
            state_d         = OUT_FULL;
            ch_d            = gnt_idx;
            type_d          = evt_type_e'(ptype_q[gnt_idx]);
            last_d          = gnt_idx;
            unload[gnt_idx] = 1'b1;
         end else begin
            state_d = OUT_EMPTY;
            ch_d    = '0;
            type_d  = EVT_FALL;
         end
      end
   end

   // A slot being unloaded this cycle is free for a new edge; otherwise a second edge is lost.
   always_comb begin
      pend_d  = pend_q;
      ptype_d = ptype_q;
      ovf_d   = clear_ovf_i ? '0 : ovf_q;
      for (int c = 0; c < NUM_CH; c++) begin
         if (unload[c]) pend_d[c] = 1'b0;
         if (edge_det[c]) begin
            if (!pend_q[c] || unload[c]) begin
               pend_d[c]  = 1'b1;
               ptype_d[c] = rise[c];
            end else begin
               ovf_d[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q  <= '0;
         pend_q  <= '0;
         ptype_q <= '0;
         ovf_q   <= '0;
         state_q <= OUT_EMPTY;
         type_q  <= EVT_FALL;
         ch_q    <= '0;
         last_q  <= CH_W'(NUM_CH - 1);
      end else begin
         prev_q  <= sig_i;
         pend_q  <= pend_d;
         ptype_q <= ptype_d;
         ovf_q   <= ovf_d;
         state_q <= state_d;
         type_q  <= type_d;
         ch_q    <= ch_d;
         last_q  <= last_d;
      end
   end

   assign evt.evt_valid_o   = (state_q == OUT_FULL);
   assign evt.evt_ch_o      = ch_q;
   assign evt.evt_is_rise_o = (type_q == EVT_RISE);
   assign pending_o         = |pend_q;
   assign overflow_o        = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_edge_event_arbiter;
   localparam int N    = 4;
   localparam int CH_W = $clog2(N);

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] sig = '0, ren = '0, fen = '0;
   logic         clr = 1'b0;
   logic         pending_o;
   logic [N-1:0] overflow_o;
   int           n_cmp = 0, n_bad = 0;
   bit           chk_en = 1'b0;

   edge_event_arbiter_if #(.CH_W(CH_W)) eif ();

   edge_event_arbiter #(.NUM_CH(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .sig_i      (sig),
      .rise_en_i  (ren),
      .fall_en_i  (fen),
      .clear_ovf_i(clr),
      .pending_o  (pending_o),
      .overflow_o (overflow_o),
      .evt        (eif)
   );

   always #5 clk = ~clk;

   // Behavioural model: slots, sticky overflow, output register and round-robin pointer.
   logic [N-1:0]    m_prev, m_pend, m_type, m_ovf;
   bit              m_valid, m_rise;
   logic [CH_W-1:0] m_ch;
   int              m_last;

   always @(posedge clk or negedge reset) begin
      logic [N-1:0] np, nt, no;
      int sel;
      bit ld, e;
      if (!reset) begin
         m_prev <= '0; m_pend <= '0; m_type <= '0; m_ovf <= '0;
         m_valid <= 1'b0; m_rise <= 1'b0; m_ch <= '0; m_last <= N - 1;
      end else begin
         ld  = !m_valid || eif.evt_ready_i;
         sel = -1;
         if (ld)
            for (int k = 1; k <= N; k++)
               if (sel < 0 && m_pend[(m_last + k) % N]) sel = (m_last + k) % N;
         np = m_pend; nt = m_type; no = clr ? '0 : m_ovf;
         for (int c = 0; c < N; c++) begin
            e = (sig[c] != m_prev[c]) && (sig[c] ? ren[c] : fen[c]);
            if (c == sel) np[c] = 1'b0;
            if (e) begin
               if (!m_pend[c] || c == sel) begin np[c] = 1'b1; nt[c] = sig[c]; end
               else no[c] = 1'b1;
            end
         end
         m_pend <= np; m_type <= nt; m_ovf <= no; m_prev <= sig;
         if (ld) begin
            if (sel >= 0) begin
               m_valid <= 1'b1; m_ch <= CH_W'(sel); m_rise <= m_type[sel]; m_last <= sel;
            end else begin
               m_valid <= 1'b0; m_ch <= '0; m_rise <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [31:0] a, x;
      if (chk_en) begin
         a = 32'({eif.evt_valid_o, eif.evt_ch_o, eif.evt_is_rise_o, pending_o, overflow_o});
         x = 32'({m_valid, m_ch, m_rise, |m_pend, m_ovf});
         n_cmp++;
         if (a !== x) begin
            n_bad++;
            $display("FAIL model_cmp t=%0t: got {v,ch,r,pend,ovf}=%h expected %h", $time, a, x);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_evt(input string nm, input bit v, input int ch, input bit r);
      chk({nm, "_valid"}, 32'(eif.evt_valid_o), 32'(v));
      chk({nm, "_ch"},    32'(eif.evt_ch_o),    32'(ch));
      chk({nm, "_rise"},  32'(eif.evt_is_rise_o), 32'(r));
   endtask

   int cnt;

   initial begin
      eif.evt_ready_i = 1'b0;
      cyc();
      chk_en = 1'b1;
      cyc();
      chk_evt("reset", 0, 0, 0);
      chk("reset_pend", 32'(pending_o), 0);
      chk("reset_ovf",  32'(overflow_o), 0);
      reset = 1'b1; ren = '1; fen = '1; eif.evt_ready_i = 1'b1;
      repeat (2) cyc();

      // Simultaneous burst from reset pointer, then a wrapping burst.
      sig = 4'b1011;
      cyc(); chk("burst_pend", 32'(pending_o), 1); chk("burst_nov", 32'(eif.evt_valid_o), 0);
      cyc(); chk_evt("burst0", 1, 0, 1);
      cyc(); chk_evt("burst1", 1, 1, 1);
      cyc(); chk_evt("burst3", 1, 3, 1);
      cyc(); chk("burst_end", 32'(eif.evt_valid_o), 0);
      fen = '0; sig = 4'b0000;
      repeat (3) cyc();
      sig = 4'b0011;
      cyc(); cyc(); chk_evt("wrap0", 1, 0, 1);
      cyc(); chk_evt("wrap1", 1, 1, 1);
      cyc(); chk("wrap_end", 32'(eif.evt_valid_o), 0);
      fen = '1;

      // Single edge latency.
      sig = 4'b0111;
      cyc(); chk("lat_n1", 32'(eif.evt_valid_o), 0);
      cyc(); chk_evt("lat_n2", 1, 2, 1);
      cyc(); chk("lat_n3", 32'(eif.evt_valid_o), 0);

      // Backpressure hold with lost edge on ch1.
      sig = 4'b0101;
      repeat (3) cyc();
      eif.evt_ready_i = 1'b0; sig = 4'b0111;
      cyc(); cyc();
      for (int i = 0; i < 10; i++) begin
         chk_evt("hold", 1, 1, 1);
         if (i == 1) sig = 4'b0101;
         if (i == 4) sig = 4'b0111;
         cyc();
      end
      chk("hold_ovf", 32'(overflow_o), 32'h2);
      chk("hold_pend", 32'(pending_o), 1);
      eif.evt_ready_i = 1'b1;
      cyc(); chk_evt("hold_fall", 1, 1, 0);
      cyc(); chk("hold_end", 32'(eif.evt_valid_o), 0);
      clr = 1'b1; cyc(); clr = 1'b0;
      chk("clr_ovf", 32'(overflow_o), 0);

      // Rise-only channel sees a full pulse.
      fen = 4'b1110; sig = 4'b0110;
      repeat (3) cyc();
      sig = 4'b0111; cyc(); sig = 4'b0110;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (eif.evt_valid_o && eif.evt_ch_o == 0 && eif.evt_is_rise_o) cnt++;
         cyc();
      end
      chk("pulse_cnt", 32'(cnt), 1);
      chk("pulse_ovf", 32'(overflow_o), 0);

      // Clear racing a new overflow.
      fen = '1; eif.evt_ready_i = 1'b0;
      sig = 4'b1110; cyc();
      sig = 4'b0110; cyc();
      sig = 4'b0010; cyc();
      sig = 4'b0110; cyc();
      chk("ovf2", 32'(overflow_o), 32'h4);
      sig = 4'b1110; clr = 1'b1; cyc(); clr = 1'b0;
      chk("ovf_race", 32'(overflow_o), 32'h8);

      // Reset mid-handshake with two channels pending.
      chk("pre_rst_valid", 32'(eif.evt_valid_o), 1);
      chk("pre_rst_pend",  32'(pending_o), 1);
      reset = 1'b0; sig = '0;
      #1;
      chk_evt("rst_async", 0, 0, 0);
      chk("rst_pend", 32'(pending_o), 0);
      chk("rst_ovf",  32'(overflow_o), 0);
      cyc(); reset = 1'b1; eif.evt_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("no_replay", 32'(eif.evt_valid_o), 0);
      end

      // Randomized traffic checked against the model.
      for (int i = 0; i < 800; i++) begin
         sig = sig ^ N'($urandom & $urandom);
         eif.evt_ready_i = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 15) == 0) begin
            ren = N'($urandom | $urandom);
            fen = N'($urandom | $urandom);
         end
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b0; cyc(); reset = 1'b1;
         end
         cyc();
      end
      cyc();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter NUM_CH, default 4, number of monitored input channels (2..16).
REQ-002 Parameter CH_W, default $clog2(NUM_CH), channel index width (derived, not overridden).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 sig_i  input  NUM_CH  level inputs, already synchronous to clk.
REQ-006 rise_en_i  input  NUM_CH  per-channel enable for rising-edge events.
REQ-007 fall_en_i  input  NUM_CH  per-channel enable for falling-edge events.
REQ-008 evt_ready_i  input  1  consumer accepts event when high with evt_valid_o.
REQ-009 clear_ovf_i  input  1  clears all overflow_o bits.
REQ-010 evt_valid_o  output  1  event available.
REQ-011 evt_ch_o  output  CH_W  channel index of presented event.
REQ-012 evt_is_rise_o  output  1  1 = rising event, 0 = falling event.
REQ-013 pending_o  output  1  OR of all per-channel pending flags.
REQ-014 overflow_o  output  NUM_CH  sticky per-channel lost-edge flags.

Function
REQ-015 Per channel, a prev register samples sig_i every cycle; rise = sig_i & ~prev & rise_en_i, fall = ~sig_i & prev & fall_en_i.
REQ-016 Each channel holds a 1-deep pending slot (flag + type bit); a detected edge with slot empty sets the flag and type at the next clock edge.
REQ-017 Edge detected while the slot is full and not being unloaded that cycle: edge dropped, overflow_o[ch] set; pending type unchanged.
REQ-018 Edge detected in the same cycle its slot is unloaded into the output register: new edge captured, no overflow.
REQ-019 Output register states: EMPTY (evt_valid_o=0) and FULL (evt_valid_o=1); load allowed when EMPTY, or FULL with evt_ready_i=1 (accept).
REQ-020 On load, round-robin arbiter selects first pending channel searching upward from last_grant+1 with wrap-around; last_grant updates to the selected channel; selected slot cleared same edge.
REQ-021 FULL with evt_ready_i=0: evt_valid_o, evt_ch_o, evt_is_rise_o held stable; no reordering.
REQ-022 FULL, accepted, no pending channel: transition to EMPTY.
REQ-023 Latency: edge condition in cycle n -> pending in cycle n+1 -> evt_valid_o high in cycle n+2 (output EMPTY, no competing channels).
REQ-024 Throughput: one event per cycle sustained while evt_ready_i=1 and events pending.
REQ-025 Deasserting rise_en_i/fall_en_i does not clear already pending events.
REQ-026 clear_ovf_i clears overflow_o; an overflow in the same cycle wins (bit set).
REQ-027 evt_ch_o and evt_is_rise_o are don't-care while evt_valid_o=0 but driven to 0.

Reset
REQ-028 reset low asynchronously clears prev, pending slots, overflow_o, output register (evt_valid_o=0, evt_ch_o=0, evt_is_rise_o=0), pending_o=0, last_grant=NUM_CH-1.
REQ-029 prev resets to 0: sig_i high at reset release produces a rising event if enabled.
REQ-030 Reset mid-handshake discards the presented event and all pending events; no event is replayed after release.

Structure
REQ-031 Package edge_arb_pkg holds evt_type_e (EVT_FALL=0, EVT_RISE=1) and the MAX_CH=16 limit constant.
REQ-032 Round-robin selection is a combinational sub-module rr_arbiter (req vector, last_grant in; grant_valid, grant_idx out).
REQ-033 Output register and per-channel slots reside in edge_event_arbiter; no FIFO beyond the 1-deep slots.

Verification
REQ-034 NUM_CH=4, all enables 1, ready=1; sig_i[2] 0->1 in cycle 5 -> evt_valid_o=1, evt_ch_o=2, evt_is_rise_o=1 in cycle 7 only.
REQ-035 Rising edges on ch0,1,3 same cycle, ready=1 -> events ch0, ch1, ch3 on three consecutive cycles; next simultaneous burst on ch0,1 -> ch0 then ch1 after last_grant=3 wraps.
REQ-036 ready=0 for 10 cycles with event ch1 presented -> outputs stable all 10 cycles; ch1 toggles 1->0->1 meanwhile -> overflow_o[1]=1, only the falling event stays pending.
REQ-037 fall_en_i[0]=0, rise_en_i[0]=1; sig_i[0] pulses 0->1->0 -> exactly one rising event; overflow_o=0.
REQ-038 clear_ovf_i=1 in the same cycle as a new overflow on ch3 -> overflow_o[3]=1, others 0.
REQ-039 reset low while evt_valid_o=1 and two channels pending -> evt_valid_o=0 immediately; after release with sig_i=0 no events appear.
